// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcode enum, status flag struct and flag bit indices.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD     = 3'b000,
    ALU_SUB     = 3'b001,
    ALU_AND     = 3'b010,
    ALU_OR      = 3'b011,
    ALU_XOR     = 3'b100,
    ALU_MUL     = 3'b101,
    ALU_XNOR    = 3'b110,
    ALU_ILLEGAL = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic err;
    logic neg;
    logic carry;
    logic zero;
  } alu_flags_t;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_NEG   = 2;
  localparam int FLAG_ERR   = 3;

endpackage

// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle for alu_pipe; slave is the ALU, master the source/sink side.
interface alu_pipe_if #(parameter int WIDTH = 8);
  import alu_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  alu_op_e              opcode;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   result;
  alu_flags_t           flags;

  modport slave (
    input  in_valid, a, b, opcode, out_ready,
    output in_ready, out_valid, result, flags
  );

  modport master (
    output in_valid, a, b, opcode, out_ready,
    input  in_ready, out_valid, result, flags
  );

endinterface

// File: rtl/alu_core.sv
// Combinational ALU datapath: (opcode, a, b) -> 2*WIDTH result and flags.
// Define ALU_SAT_EN to make ADD/SUB saturate instead of wrapping/extending.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  alu_op_e              i_op,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  output logic [2*WIDTH-1:0]   o_result,
  output alu_flags_t           o_flags
);

  localparam int RW = 2 * WIDTH;

  logic [WIDTH:0]  w_sum;
  logic [RW-1:0]   w_a_ext;
  logic [RW-1:0]   w_b_ext;
  logic [RW-1:0]   w_diff;
  logic [RW-1:0]   w_prod;
  logic [RW-1:0]   w_result;
  logic            w_carry;
  logic            w_err;

  // Operands are zero-extended first, so logic ops (XNOR included) act on the full result width.
  assign w_a_ext = {{WIDTH{1'b0}}, i_a};
  assign w_b_ext = {{WIDTH{1'b0}}, i_b};
  assign w_sum   = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff  = w_a_ext - w_b_ext;
  assign w_prod  = w_a_ext * w_b_ext;

  always_comb begin
    // NOTE: every output of this block gets a default before the case, so no path can infer a latch.
    w_result = '0;
    w_carry  = 1'b0;
    w_err    = 1'b0;
    case (i_op)
      ALU_ADD: begin
        w_carry = w_sum[WIDTH];
`ifdef ALU_SAT_EN
        w_result = w_carry ? {{WIDTH{1'b0}}, {WIDTH{1'b1}}} : {{(WIDTH-1){1'b0}}, w_sum};
`else
        w_result = {{(WIDTH-1){1'b0}}, w_sum};
`endif
      end
      ALU_SUB: begin
        w_carry = (i_a < i_b);
`ifdef ALU_SAT_EN
        w_result = w_carry ? '0 : w_diff;
`else
        w_result = w_diff;
`endif
      end
      ALU_AND:  w_result = w_a_ext & w_b_ext;
      ALU_OR:   w_result = w_a_ext | w_b_ext;
      ALU_XOR:  w_result = w_a_ext ^ w_b_ext;
      ALU_XNOR: w_result = ~(w_a_ext ^ w_b_ext);
      ALU_MUL: begin
        w_result = w_prod;
        w_carry  = |w_prod[RW-1:WIDTH];
      end
      default:  w_err = 1'b1;
    endcase
  end

  assign o_result      = w_result;
  assign o_flags.err   = w_err;
  assign o_flags.neg   = w_result[RW-1];
  assign o_flags.carry = w_carry;
  assign o_flags.zero  = (w_result == '0);

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready on both sides: stage 1 holds operands, stage 2 the result.
// Optional build macro ALU_SAT_EN (saturating ADD/SUB) is handled inside alu_core.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_pipe_if.slave  bus
);

  logic                 w_adv1;
  logic                 w_adv2;

  logic                 r_s1_valid;
  logic [WIDTH-1:0]     r_s1_a;
  logic [WIDTH-1:0]     r_s1_b;
  alu_op_e              r_s1_op;

  logic                 r_s2_valid;
  logic [2*WIDTH-1:0]   r_result;
  alu_flags_t           r_flags;

  logic [2*WIDTH-1:0]   w_core_result;
  alu_flags_t           w_core_flags;

  // A stage may load when it is empty or its content moves on this same edge.
  assign w_adv2      = !r_s2_valid || bus.out_ready;
  assign w_adv1      = !r_s1_valid || w_adv2;
  assign bus.in_ready = w_adv1;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: data registers are reset as well as valids, so a reset leaves no stale operand or result visible.
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_op    <= ALU_ADD;
    end else if (w_adv1) begin
      // NOTE: non-blocking assignments keep both stages reading pre-edge values when they advance together.
      r_s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1_a  <= bus.a;
        r_s1_b  <= bus.b;
        r_s1_op <= bus.opcode;
      end
    end
  end

  alu_core #(.WIDTH(WIDTH)) u_core (
    .i_op     (r_s1_op),
    .i_a      (r_s1_a),
    .i_b      (r_s1_b),
    .o_result (w_core_result),
    .o_flags  (w_core_flags)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_result   <= '0;
      r_flags    <= '0;
    end else if (w_adv2) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_result <= w_core_result;
        r_flags  <= w_core_flags;
      end
    end
  end

  assign bus.out_valid = r_s2_valid;
  assign bus.result    = r_result;
  assign bus.flags     = r_flags;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed cases plus randomized traffic against a scoreboard model.
module tb_alu_pipe;
  import alu_pkg::*;

  typedef struct {
    longint unsigned res;
    logic [3:0]      fl;
  } exp_t;

  logic clk;
  logic rst_n;

  alu_pipe_if #(.WIDTH(8))  bus ();
  alu_pipe_if #(.WIDTH(16)) bus16 ();

  alu_pipe #(.WIDTH(8))  dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
  alu_pipe #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  exp_t        sb[$];
  logic [63:0] got_res[$];
  logic [3:0]  got_fl[$];
  logic        hold_pending = 1'b0;
  logic [15:0] hold_res;
  logic [3:0]  hold_fl;
  logic        last_acc;
  logic        last_ready;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference behaviour from the arithmetic rules, at arbitrary width w.
  function automatic exp_t model(int w, int op, longint unsigned a, longint unsigned b);
    exp_t            e;
    longint unsigned m2 = (64'd1 << (2 * w)) - 1;
    longint unsigned r  = 0;
    bit              c  = 0;
    bit              er = 0;
    case (op)
      0: begin
        r = a + b;
        c = (r >= (64'd1 << w));
`ifdef ALU_SAT_EN
        if (c) r = (64'd1 << w) - 1;
`endif
      end
      1: begin
        c = (a < b);
        r = (a - b) & m2;
`ifdef ALU_SAT_EN
        if (c) r = 0;
`endif
      end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin
        r = a * b;
        c = (r >= (64'd1 << w));
      end
      6: r = ~(a ^ b) & m2;
      default: begin
        er = 1;
        r  = 0;
      end
    endcase
    e.res = r;
    e.fl  = '0;
    e.fl[FLAG_ERR]   = er;
    e.fl[FLAG_NEG]   = ((r >> (2 * w - 1)) & 1) != 0;
    e.fl[FLAG_CARRY] = c;
    e.fl[FLAG_ZERO]  = (r == 0);
    return e;
  endfunction

  task automatic drive(input bit v, input int op, input longint unsigned a, input longint unsigned b);
    bus.in_valid = v;
    bus.opcode   = alu_op_e'(op[2:0]);
    bus.a        = a[7:0];
    bus.b        = b[7:0];
  endtask

  // One clock cycle: sample mid-low-phase, score handshakes, then advance to the next falling edge.
  task automatic step();
    exp_t e;
    #1;
    if (hold_pending) begin
      check("hold_res", bus.result, hold_res);
      check("hold_flags", bus.flags, hold_fl);
    end
    hold_pending = bus.out_valid && !bus.out_ready;
    hold_res     = bus.result;
    hold_fl      = bus.flags;
    last_ready   = bus.in_ready;
    last_acc     = bus.in_valid && bus.in_ready;
    if (bus.out_valid && bus.out_ready) begin
      got_res.push_back(bus.result);
      got_fl.push_back(bus.flags);
      if (sb.size() == 0) check("spurious_out", bus.out_valid, 0);
      else begin
        e = sb.pop_front();
        check("sb_res", bus.result, e.res);
        check("sb_flags", bus.flags, e.fl);
      end
    end
    if (last_acc) sb.push_back(model(8, bus.opcode, bus.a, bus.b));
    @(negedge clk);
  endtask

  task automatic send(input int op, input longint unsigned a, input longint unsigned b);
    drive(1, op, a, b);
    for (int k = 0; k < 20; k++) begin
      step();
      if (last_acc) break;
    end
    if (!last_acc) check("accept_timeout", bus.in_ready, 1);
    drive(0, 0, 0, 0);
  endtask

  task automatic drain(output int cycles);
    cycles = 0;
    for (int k = 0; k < 40 && sb.size() > 0; k++) begin
      step();
      cycles++;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  task automatic one(input string tag, input int op, input longint unsigned a, input longint unsigned b,
                     input logic [63:0] exp_res, input logic [3:0] exp_fl);
    int n;
    got_res.delete();
    got_fl.delete();
    send(op, a, b);
    drain(n);
    check({tag, "_count"}, got_res.size(), 1);
    if (got_res.size() > 0) begin
      check({tag, "_res"}, got_res[0], exp_res);
      check({tag, "_flags"}, got_fl[0], exp_fl);
    end
  endtask

  logic [63:0] t1_exp [7] = '{15, 5, 0, 15, 15, 50, 64'hFFF0};
  logic [63:0] t16_exp[8] = '{15, 5, 0, 15, 15, 50, 64'hFFFF_FFF0, 64'hFFFE_0001};
  int          t4_op  [3] = '{5, 4, 3};
  int          t4_a   [3] = '{3, 6, 8};
  int          t4_b   [3] = '{4, 3, 1};
  logic [63:0] t4_exp [3] = '{12, 5, 9};

  initial begin
    int n;
    int idx;
    logic [63:0] g16[$];
    logic [3:0]  f16[$];

    rst_n = 1'b0;
    drive(0, 0, 0, 0);
    bus.out_ready   = 1'b1;
    bus16.in_valid  = 1'b0;
    bus16.opcode    = ALU_ADD;
    bus16.a         = '0;
    bus16.b         = '0;
    bus16.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_result", bus.result, 0);
    check("rst_flags", bus.flags, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Latency: beat offered before edge 1, result visible after edge 2.
    drive(1, 0, 1, 2);
    step();
    drive(0, 0, 0, 0);
    check("lat_edge1_valid", bus.out_valid, 0);
    step();
    check("lat_edge2_valid", bus.out_valid, 1);
    drain(n);

    // Back-to-back ops 000..110 with a=10, b=5.
    got_res.delete();
    got_fl.delete();
    for (int i = 0; i < 7; i++) begin
      drive(1, i, 10, 5);
      step();
      check("t1_accept", last_acc, 1);
    end
    drive(0, 0, 0, 0);
    drain(n);
    check("t1_tail_cycles", n, 2);
    check("t1_count", got_res.size(), 7);
    for (int i = 0; i < 7 && i < got_res.size(); i++) check("t1_res", got_res[i], t1_exp[i]);

`ifdef ALU_SAT_EN
    one("add_ovf", 0, 8'hFF, 8'h01, 64'h00FF, 4'b0010);
    one("sub_0_1", 1, 0, 1, 64'h0000, 4'b0011);
`else
    one("add_ovf", 0, 8'hFF, 8'h01, 64'h0100, 4'b0010);
    one("sub_0_1", 1, 0, 1, 64'hFFFF, 4'b0110);
`endif
    one("sub_0_0", 1, 0, 0, 64'h0, 4'b0001);
    one("illegal", 7, 3, 4, 64'h0, 4'b1001);
    one("mul_max", 5, 8'hFF, 8'hFF, 64'hFE01, 4'b0110);

    // Backpressure: three beats offered into a stalled sink.
    got_res.delete();
    got_fl.delete();
    bus.out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      drive(1, t4_op[idx], t4_a[idx], t4_b[idx]);
      step();
      check("t4_in_ready", last_ready, (c < 2) ? 1 : 0);
      if (last_acc) idx++;
    end
    check("t4_accepted", idx, 2);
    check("t4_none_out", got_res.size(), 0);
    bus.out_ready = 1'b1;
    send(t4_op[2], t4_a[2], t4_b[2]);
    drain(n);
    check("t4_count", got_res.size(), 3);
    for (int i = 0; i < 3 && i < got_res.size(); i++) check("t4_order", got_res[i], t4_exp[i]);

    // Randomized traffic with random backpressure.
    drive(0, 0, 0, 0);
    for (int c = 0; c < 400; c++) begin
      bus.out_ready = ($urandom_range(3) != 0);
      if (!bus.in_valid || last_acc) begin
        drive($urandom_range(2) != 0, $urandom_range(7),
              ($urandom_range(4) == 0) ? 8'hFF : $urandom_range(255),
              ($urandom_range(4) == 0) ? 8'h00 : $urandom_range(255));
      end
      step();
    end
    drive(0, 0, 0, 0);
    bus.out_ready = 1'b1;
    drain(n);

    // Reset with two beats in flight.
    bus.out_ready = 1'b0;
    send(5, 7, 9);
    send(0, 1, 1);
    check("rst_pre_valid", bus.out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_result", bus.result, 0);
    check("mid_rst_flags", bus.flags, 0);
    check("mid_rst_in_ready", bus.in_ready, 1);
    sb.delete();
    hold_pending = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    got_res.delete();
    repeat (6) step();
    check("post_rst_silent", got_res.size(), 0);

    // Same back-to-back sequence on the 16-bit instance, plus the full-range multiply.
    for (int c = 0; c < 14; c++) begin
      if (c < 8) begin
        bus16.in_valid = 1'b1;
        bus16.opcode   = alu_op_e'((c < 7) ? c[2:0] : 3'd5);
        bus16.a        = (c < 7) ? 16'd10 : 16'hFFFF;
        bus16.b        = (c < 7) ? 16'd5  : 16'hFFFF;
      end else begin
        bus16.in_valid = 1'b0;
      end
      #1;
      if (bus16.in_valid) check("w16_in_ready", bus16.in_ready, 1);
      if (bus16.out_valid) begin
        g16.push_back(bus16.result);
        f16.push_back(bus16.flags);
      end
      @(negedge clk);
    end
    check("w16_count", g16.size(), 8);
    for (int i = 0; i < 8 && i < g16.size(); i++) check("w16_res", g16[i], t16_exp[i]);
    if (f16.size() == 8) check("w16_mul_flags", f16[7], 4'b0110);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
